// File: rtl/fib_timer_pkg.sv
// Shared types and constants for the Fibonacci/timer counter board.
package fib_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIB  = 2'd1,
        TMR  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return {HEX_SEG[nib], 1'b1};
    endfunction

endpackage

// File: rtl/fib_timer_top_seg_scan.sv
// Eight-digit multiplexed 7-segment scanner: scan counter, anode decode
// and segment lookup from per-digit hex codes and blank flags.
module seg_scan #(
    parameter int unsigned SCAN_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0][3:0] i_code,
    input  logic [7:0]      i_blank,
    output logic [7:0]      o_an,
    output logic [7:0]      o_seg
);
    import fib_timer_pkg::*;

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;

    // Dwell SCAN_DIV cycles per digit, then move to the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_comb begin
        o_an  = ~(8'd1 << r_idx);
        o_seg = i_blank[r_idx] ? SEG_BLANK : hex_to_seg(i_code[r_idx]);
    end

endmodule

// File: rtl/fib_timer_top.sv
// Two-mode counter board: Fibonacci stepper or up-timer advanced by a
// programmable tick, shown on a scanned hex display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero value digits 3..1.
module fib_timer_top #(
    parameter int unsigned BASE_DIV = 4,
    parameter int unsigned SCAN_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_f,
    input  logic       start_t,
    input  logic       stop_f_t,
    input  logic       update,
    input  logic [2:0] prog,
    output logic [5:0] led,
    output logic [7:0] an,
    output logic [7:0] dec_ddp,
    output logic       parity
);
    import fib_timer_pkg::*;

    localparam int unsigned CNT_W = $clog2(BASE_DIV << 7) + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_rate;
    logic [15:0]     r_value;
    logic [15:0]     r_fa;
    logic [15:0]     r_fb;
    logic            r_fib_ovf;
    logic            r_tick_led;
    logic [CNT_W-1:0] r_tick_cnt;

    logic [CNT_W-1:0] w_period;
    logic             w_tick;
    logic             w_start_f;
    logic             w_start_t;
    logic             w_adv;
    logic [16:0]      w_fib_sum;
    logic [7:0][3:0]  w_codes;
    logic [7:0]       w_blank;

    assign w_period  = CNT_W'(BASE_DIV) << r_rate;
    assign w_tick    = (r_state != IDLE) && (r_tick_cnt == w_period - CNT_W'(1));
    assign w_fib_sum = {1'b0, r_fa} + {1'b0, r_fb};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stop beats start and tick; starts only count from IDLE, FIB wins a tie
    always_comb begin
        w_state_nxt = r_state;
        w_start_f   = 1'b0;
        w_start_t   = 1'b0;
        w_adv       = 1'b0;
        if (stop_f_t) begin
            w_state_nxt = IDLE;
        end else if (r_state == IDLE) begin
            if (start_f) begin
                w_state_nxt = FIB;
                w_start_f   = 1'b1;
            end else if (start_t) begin
                w_state_nxt = TMR;
                w_start_t   = 1'b1;
            end
        end else begin
            w_adv = w_tick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rate     <= '0;
            r_value    <= '0;
            r_fa       <= '0;
            r_fb       <= 16'd1;
            r_fib_ovf  <= 1'b0;
            r_tick_led <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            if (update) begin
                r_rate <= prog;
            end

            if (update || w_start_f || w_start_t) begin
                r_tick_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            end

            if (w_start_f) begin
                r_value   <= '0;
                r_fa      <= '0;
                r_fb      <= 16'd1;
                r_fib_ovf <= 1'b0;
            end else if (w_start_t) begin
                r_value <= '0;
            end else if (w_adv) begin
                r_tick_led <= ~r_tick_led;
                if (r_state == FIB) begin
                    // Overflow is remembered so 0xB520 is still shown before the 0 restart
                    if (r_fib_ovf) begin
                        r_value   <= '0;
                        r_fa      <= '0;
                        r_fb      <= 16'd1;
                        r_fib_ovf <= 1'b0;
                    end else begin
                        r_value   <= r_fb;
                        r_fa      <= r_fb;
                        r_fb      <= w_fib_sum[15:0];
                        r_fib_ovf <= w_fib_sum[16];
                    end
                end else begin
                    r_value <= r_value + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_codes    = '0;
        w_codes[0] = r_value[3:0];
        w_codes[1] = r_value[7:4];
        w_codes[2] = r_value[11:8];
        w_codes[3] = r_value[15:12];
        w_codes[4] = {1'b0, r_rate};
        w_blank    = 8'b1110_0000;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank[3] = (r_value[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_value[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_value[7:4] == 4'd0);
`endif
    end

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk     (clk),
        .rst     (rst),
        .i_code  (w_codes),
        .i_blank (w_blank),
        .o_an    (an),
        .o_seg   (dec_ddp)
    );

    assign led    = {r_tick_led, r_state == TMR, r_state == FIB, r_rate};
    assign parity = ^r_value;

endmodule

// File: tb/tb_fib_timer_top.sv
// Directed bench for fib_timer_top with a cycle-level behavioural model.
module tb_fib_timer_top;

    localparam int unsigned BASE_DIV = 4;
    localparam int unsigned SCAN_DIV = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_f;
    logic       start_t;
    logic       stop_f_t;
    logic       update;
    logic [2:0] prog;
    logic [5:0] led;
    logic [7:0] an;
    logic [7:0] dec_ddp;
    logic       parity;

    fib_timer_top #(
        .BASE_DIV (BASE_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_f  (start_f),
        .start_t  (start_t),
        .stop_f_t (stop_f_t),
        .update   (update),
        .prog     (prog),
        .led      (led),
        .an       (an),
        .dec_ddp  (dec_ddp),
        .parity   (parity)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    int fib_tbl [25];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 idle / 1 fib / 2 timer; value is a function of ticks since start
    int         m_mode = 0;
    int         m_seq = 0;
    int         m_ticks = 0;
    int         m_cnt = 0;
    int         m_sc = 0;
    logic [2:0] m_rate = 3'd0;
    bit         m_led5 = 1'b0;
    bit         m_valid = 1'b0;

    function automatic int period_of(input logic [2:0] r);
        return int'(BASE_DIV) << r;
    endfunction

    function automatic logic [15:0] mval();
        if (m_seq == 1) return 16'(fib_tbl[m_ticks % 25]);
        if (m_seq == 2) return 16'(m_ticks);
        return 16'h0000;
    endfunction

    function automatic logic [7:0] exp_seg(input int idx, input logic [15:0] v, input logic [2:0] r);
        logic [3:0] nib;
        if (idx < 4) begin
            nib = 4'(v >> (4 * idx));
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && (v >> (4 * idx)) == 16'h0000) return 8'hFF;
`endif
            return {seg_tbl[nib], 1'b1};
        end
        if (idx == 4) return {seg_tbl[{1'b0, r}], 1'b1};
        return 8'hFF;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode  <= 0;
            m_seq   <= 0;
            m_ticks <= 0;
            m_cnt   <= 0;
            m_sc    <= 0;
            m_rate  <= 3'd0;
            m_led5  <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            m_sc <= m_sc + 1;
            if (update) m_rate <= prog;
            if (stop_f_t) begin
                m_mode <= 0;
            end else if (m_mode == 0 && (start_f || start_t)) begin
                m_mode  <= start_f ? 1 : 2;
                m_seq   <= start_f ? 1 : 2;
                m_ticks <= 0;
            end else if (m_mode != 0 && (m_cnt % period_of(m_rate)) == period_of(m_rate) - 1) begin
                m_ticks <= m_ticks + 1;
                m_led5  <= !m_led5;
            end
            if (update || (!stop_f_t && m_mode == 0 && (start_f || start_t))) m_cnt <= 0;
            else if (m_mode != 0) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_loop();
        int         idx;
        logic [7:0] exp_an;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                idx    = (m_sc / int'(SCAN_DIV)) % 8;
                exp_an = ~(8'd1 << idx);
                chk("an", 32'(an), 32'(exp_an));
                chk("dec_ddp", 32'(dec_ddp), 32'(exp_seg(idx, mval(), m_rate)));
                chk("led", 32'(led), 32'({m_led5, m_mode == 2, m_mode == 1, m_rate}));
                chk("parity", 32'(parity), 32'(^mval()));
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_upd(input logic [2:0] p);
        update = 1'b1;
        prog   = p;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic do_start(input logic f, input logic t);
        start_f = f;
        start_t = t;
        @(negedge clk);
        start_f = 1'b0;
        start_t = 1'b0;
    endtask

    task automatic do_stop();
        stop_f_t = 1'b1;
        @(negedge clk);
        stop_f_t = 1'b0;
    endtask

    task automatic check_digit(input string name, input int idx, input logic [7:0] exp);
        logic [7:0] exp_an;
        exp_an = ~(8'd1 << idx);
        for (int i = 0; i < 40 && an !== exp_an; i++) @(negedge clk);
        chk({name, "_an"}, 32'(an), 32'(exp_an));
        chk(name, 32'(dec_ddp), 32'(exp));
    endtask

    int lit_fib [6] = '{0, 1, 1, 2, 3, 5};
    int lit_par [6] = '{0, 1, 1, 1, 0, 0};

    initial begin
        rst = 1'b1; start_f = 1'b0; start_t = 1'b0; stop_f_t = 1'b0;
        update = 1'b0; prog = 3'd0;
        fib_tbl[0] = 0;
        fib_tbl[1] = 1;
        for (int i = 2; i < 25; i++) fib_tbl[i] = fib_tbl[i-1] + fib_tbl[i-2];
        fork
            cmp_loop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'h000000FE);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_parity", 32'(parity), 32'h0);
        chk("rst_dec", 32'(dec_ddp), 32'h03);
        rst = 1'b0;

        // Fibonacci at rate 3 (32-cycle tick)
        do_upd(3'd3);
        do_start(1'b1, 1'b0);
        chk("fib_entry_led", 32'(led), 32'(6'b001011));
        chk("fib_v0", 32'(mval()), 32'(lit_fib[0]));
        for (int k = 1; k < 6; k++) begin
            wait_cyc(32);
            chk("fib_seq", 32'(mval()), 32'(lit_fib[k]));
            chk("fib_parity", 32'(parity), 32'(lit_par[k]));
        end
        do_stop();
        chk("fib_stop_led", 32'(led), 32'(6'b100011));
        wait_cyc(40);
        chk("fib_frozen", 32'(mval()), 32'd5);
        chk("fib_frozen_par", 32'(parity), 32'd0);

        // Timer at rate 3, stopped after 40 cycles
        do_start(1'b0, 1'b1);
        chk("tmr_entry_led", 32'(led), 32'(6'b110011));
        wait_cyc(39);
        do_stop();
        chk("tmr_hold", 32'(mval()), 32'd1);
        chk("tmr_hold_par", 32'(parity), 32'd1);
        chk("tmr_stop_led", 32'(led), 32'(6'b000011));

        // Rate 5 in IDLE; stop lands on the first tick
        do_upd(3'd5);
        chk("rate5_led", 32'(led), 32'(6'b000101));
        check_digit("dig4_rate5", 4, 8'h49);
        do_start(1'b1, 1'b0);
        wait_cyc(127);
        do_stop();
        chk("stop_on_tick_val", 32'(mval()), 32'd0);
        chk("stop_on_tick_led", 32'(led), 32'(6'b000101));

        // Timer at rate 0 (4-cycle tick)
        do_upd(3'd0);
        do_start(1'b0, 1'b1);
        wait_cyc(12);
        chk("tmr3", 32'(mval()), 32'd3);
        chk("tmr3_par", 32'(parity), 32'd0);
        wait_cyc(4 * 297);
        chk("tmr300", 32'(mval()), 32'h12C);
        do_stop();
        check_digit("dig2_one", 2, 8'h9F);
`ifdef LEADING_ZERO_BLANK_EN
        check_digit("dig3_zero", 3, 8'hFF);
`else
        check_digit("dig3_zero", 3, 8'h03);
`endif

        // Fibonacci wrap at rate 0
        do_start(1'b1, 1'b0);
        wait_cyc(4 * 24);
        chk("fib_b520", 32'(mval()), 32'hB520);
        chk("fib_b520_par", 32'(parity), 32'd0);
        wait_cyc(4);
        chk("fib_wrap0", 32'(mval()), 32'd0);
        wait_cyc(4);
        chk("fib_wrap1", 32'(mval()), 32'd1);

        // Start ignored outside IDLE; stop beats start; FIB wins a tie
        do_start(1'b0, 1'b1);
        chk("start_ignored", 32'(led[4:3]), 32'b01);
        do_stop();
        start_t  = 1'b1;
        stop_f_t = 1'b1;
        @(negedge clk);
        start_t  = 1'b0;
        stop_f_t = 1'b0;
        chk("stop_beats_start", 32'(led[4:3]), 32'b00);
        do_start(1'b1, 1'b1);
        chk("tie_fib", 32'(led[4:3]), 32'b01);
        chk("tie_val", 32'(mval()), 32'd0);
        wait_cyc(20);
        do_stop();
        wait_cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
